// File: rtl/vgatiming_param_gen_if.sv
// Display-side bundle for vgatiming_param_gen: run enable in, sync/blank/request/coordinate outputs.
// oFRAME_CNT exists only when VGATIMING_FRAME_CNT_EN is defined.
interface vgatiming_param_gen_if #(
  parameter int P_CNT_W = 11
);
  logic               iENABLE;
  logic               oDATA_REQ;
  logic [P_CNT_W-1:0] oDATA_X;
  logic [P_CNT_W-1:0] oDATA_Y;
  logic               oLINE_START;
  logic               oFRAME_START;
  logic               oDISP_HSYNC;
  logic               oDISP_VSYNC;
  logic               oDISP_BLANK;
`ifdef VGATIMING_FRAME_CNT_EN
  logic [15:0]        oFRAME_CNT;
`endif

  // master = timing generator, slave = framebuffer reader / DAC side
  modport master (
    input  iENABLE,
    output oDATA_REQ, oDATA_X, oDATA_Y, oLINE_START, oFRAME_START,
`ifdef VGATIMING_FRAME_CNT_EN
    output oFRAME_CNT,
`endif
    output oDISP_HSYNC, oDISP_VSYNC, oDISP_BLANK
  );

  modport slave (
    output iENABLE,
    input  oDATA_REQ, oDATA_X, oDATA_Y, oLINE_START, oFRAME_START,
`ifdef VGATIMING_FRAME_CNT_EN
    input  oFRAME_CNT,
`endif
    input  oDISP_HSYNC, oDISP_VSYNC, oDISP_BLANK
  );
endinterface

// File: rtl/vgatiming_param_gen.sv
// Parametrised VGA timing generator: registered sync/blank, lead-adjustable pixel request with X/Y.
// Optional 16-bit frame counter output when VGATIMING_FRAME_CNT_EN is defined.
module vgatiming_param_gen #(
  parameter int P_H_SYNC   = 96,
  parameter int P_H_BACK   = 48,
  parameter int P_H_ACTIVE = 640,
  parameter int P_H_FRONT  = 16,
  parameter int P_V_SYNC   = 2,
  parameter int P_V_BACK   = 33,
  parameter int P_V_ACTIVE = 480,
  parameter int P_V_FRONT  = 10,
  parameter bit P_HS_POL   = 1'b0,
  parameter bit P_VS_POL   = 1'b0,
  parameter int P_REQ_LEAD = 1,
  parameter int P_CNT_W    = 11
) (
  input  logic                  iVGA_CLOCK,
  input  logic                  inRESET,
  vgatiming_param_gen_if.master vga
);

  localparam int H_TOTAL = P_H_SYNC + P_H_BACK + P_H_ACTIVE + P_H_FRONT;
  localparam int V_TOTAL = P_V_SYNC + P_V_BACK + P_V_ACTIVE + P_V_FRONT;

  localparam logic [P_CNT_W-1:0] H_LAST     = P_CNT_W'(H_TOTAL - 1);
  localparam logic [P_CNT_W-1:0] V_LAST     = P_CNT_W'(V_TOTAL - 1);
  localparam logic [P_CNT_W-1:0] H_SYNC_END = P_CNT_W'(P_H_SYNC);
  localparam logic [P_CNT_W-1:0] V_SYNC_END = P_CNT_W'(P_V_SYNC);
  localparam logic [P_CNT_W-1:0] HA0        = P_CNT_W'(P_H_SYNC + P_H_BACK);
  localparam logic [P_CNT_W-1:0] HA_END     = P_CNT_W'(P_H_SYNC + P_H_BACK + P_H_ACTIVE);
  localparam logic [P_CNT_W-1:0] VA0        = P_CNT_W'(P_V_SYNC + P_V_BACK);
  localparam logic [P_CNT_W-1:0] VA_END     = P_CNT_W'(P_V_SYNC + P_V_BACK + P_V_ACTIVE);
  localparam logic [P_CNT_W-1:0] HR0        = P_CNT_W'(P_H_SYNC + P_H_BACK - P_REQ_LEAD);
  localparam logic [P_CNT_W-1:0] HR_END     = P_CNT_W'(P_H_SYNC + P_H_BACK - P_REQ_LEAD + P_H_ACTIVE);

  if (P_REQ_LEAD > P_H_BACK) begin : g_bad_lead
    $error("vgatiming_param_gen: P_REQ_LEAD exceeds P_H_BACK");
  end
  if ((longint'(H_TOTAL) > (longint'(1) << P_CNT_W)) ||
      (longint'(V_TOTAL) > (longint'(1) << P_CNT_W))) begin : g_bad_width
    $error("vgatiming_param_gen: P_CNT_W too narrow for line/frame totals");
  end

  logic [P_CNT_W-1:0] h_q, h_d;
  logic [P_CNT_W-1:0] v_q, v_d;
  logic [P_CNT_W-1:0] x_q, x_d;
  logic [P_CNT_W-1:0] y_q, y_d;
  logic               req_q, req_d;
  logic               line_q, line_d;
  logic               frame_q, frame_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               blank_q, blank_d;

  logic h_act, v_act, h_req;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!vga.iENABLE) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  // Everything below decodes the current (h,v); the registers present it one cycle later.
  always_comb begin
    h_act   = (h_q >= HA0) && (h_q < HA_END);
    v_act   = (v_q >= VA0) && (v_q < VA_END);
    h_req   = (h_q >= HR0) && (h_q < HR_END);
    hs_d    = ~P_HS_POL;
    vs_d    = ~P_VS_POL;
    blank_d = 1'b1;
    req_d   = 1'b0;
    line_d  = 1'b0;
    frame_d = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    if (!vga.iENABLE) begin
      x_d = '0;
      y_d = '0;
    end else begin
      hs_d    = (h_q < H_SYNC_END) ? P_HS_POL : ~P_HS_POL;
      vs_d    = (v_q < V_SYNC_END) ? P_VS_POL : ~P_VS_POL;
      blank_d = ~(h_act && v_act);
      req_d   = h_req && v_act;
      line_d  = (h_q == '0);
      frame_d = (h_q == '0) && (v_q == '0);
      if (req_d) begin
        x_d = (h_q == HR0) ? '0 : x_q + 1'b1;
        y_d = v_q - VA0;
      end
    end
  end

  always_ff @(posedge iVGA_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      h_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      req_q   <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      hs_q    <= ~P_HS_POL;
      vs_q    <= ~P_VS_POL;
      blank_q <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      x_q     <= x_d;
      y_q     <= y_d;
      req_q   <= req_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
    end
  end

`ifdef VGATIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Steps on the same edge that raises oFRAME_START; a disabled generator never pulses, so it holds.
  always_comb begin
    frame_cnt_d = frame_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge iVGA_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vga.oFRAME_CNT = frame_cnt_q;
`endif

  assign vga.oDATA_REQ    = req_q;
  assign vga.oDATA_X      = x_q;
  assign vga.oDATA_Y      = y_q;
  assign vga.oLINE_START  = line_q;
  assign vga.oFRAME_START = frame_q;
  assign vga.oDISP_HSYNC  = hs_q;
  assign vga.oDISP_VSYNC  = vs_q;
  assign vga.oDISP_BLANK  = blank_q;

endmodule

// File: tb/tb_vgatiming_param_gen.sv
// Directed bench for vgatiming_param_gen on a miniature mode (17 clocks x 8 lines, 136-clock frame).
// Checks oFRAME_CNT as well when VGATIMING_FRAME_CNT_EN is defined.
module tb_vgatiming_param_gen;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vgatiming_param_gen_if #(.P_CNT_W(W)) vga ();

  // H: sync 3, back 4, active 8, front 2 -> HA0=7, request window [5,13) with lead 2
  // V: sync 2, back 2, active 3, front 1 -> VA0=4, active lines 4..6
  vgatiming_param_gen #(
    .P_H_SYNC(3), .P_H_BACK(4), .P_H_ACTIVE(8), .P_H_FRONT(2),
    .P_V_SYNC(2), .P_V_BACK(2), .P_V_ACTIVE(3), .P_V_FRONT(1),
    .P_HS_POL(1'b0), .P_VS_POL(1'b1), .P_REQ_LEAD(2), .P_CNT_W(W)
  ) dut (
    .iVGA_CLOCK(clk),
    .inRESET   (rst_n),
    .vga       (vga)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hsync"}, 32'(vga.oDISP_HSYNC), 32'd1);
    check({tag, "_vsync"}, 32'(vga.oDISP_VSYNC), 32'd0);
    check({tag, "_blank"}, 32'(vga.oDISP_BLANK), 32'd1);
    check({tag, "_req"}, 32'(vga.oDATA_REQ), 32'd0);
    check({tag, "_x"}, 32'(vga.oDATA_X), 32'd0);
    check({tag, "_y"}, 32'(vga.oDATA_Y), 32'd0);
    check({tag, "_line"}, 32'(vga.oLINE_START), 32'd0);
    check({tag, "_frame"}, 32'(vga.oFRAME_START), 32'd0);
  endtask

  initial begin
    int hs_line, hs_frame, vs_frame, blank_cnt, req_cnt, fs_cnt, ls_cnt;
    int first_blank, first_req, req_k;
    hs_line = 0; hs_frame = 0; vs_frame = 0; blank_cnt = 0; req_cnt = 0;
    fs_cnt = 0; ls_cnt = 0; first_blank = -1; first_req = -1; req_k = 0;

    rst_n = 1'b0;
    vga.iENABLE = 1'b0;
    step();
    step();
    check_idle("reset");
`ifdef VGATIMING_FRAME_CNT_EN
    check("reset_fcnt", 32'(vga.oFRAME_CNT), 32'd0);
`endif
    #2 rst_n = 1'b1;
    step();
    check_idle("disabled");

    vga.iENABLE = 1'b1;
    // Sample n reflects counter state n: h = n%17, v = (n/17)%8
    for (int n = 0; n < 272; n++) begin
      step();
      if (n == 0) begin
        check("en_frame_start", 32'(vga.oFRAME_START), 32'd1);
        check("en_line_start", 32'(vga.oLINE_START), 32'd1);
        check("en_hsync", 32'(vga.oDISP_HSYNC), 32'd0);
        check("en_vsync", 32'(vga.oDISP_VSYNC), 32'd1);
        check("en_blank", 32'(vga.oDISP_BLANK), 32'd1);
`ifdef VGATIMING_FRAME_CNT_EN
        check("en_fcnt", 32'(vga.oFRAME_CNT), 32'd1);
`endif
      end
      if (n == 1) begin
        check("h1_frame_start", 32'(vga.oFRAME_START), 32'd0);
        check("h1_line_start", 32'(vga.oLINE_START), 32'd0);
      end
      if (n == 3) check("h3_hsync", 32'(vga.oDISP_HSYNC), 32'd1);
      if (n < 17 && vga.oDISP_HSYNC == 1'b0) hs_line++;
      if (n < 136) begin
        if (vga.oDISP_HSYNC == 1'b0) hs_frame++;
        if (vga.oDISP_VSYNC == 1'b1) vs_frame++;
        if (vga.oDISP_BLANK == 1'b0) begin
          blank_cnt++;
          if (first_blank < 0) first_blank = n;
        end
        if (vga.oDATA_REQ == 1'b1) begin
          req_cnt++;
          if (first_req < 0) first_req = n;
          check("req_x", 32'(vga.oDATA_X), 32'(req_k % 8));
          check("req_y", 32'(vga.oDATA_Y), 32'(req_k / 8));
          req_k++;
        end
      end
      if (vga.oFRAME_START) fs_cnt++;
      if (vga.oLINE_START) ls_cnt++;
      if (n == 81) begin
        check("hold_req", 32'(vga.oDATA_REQ), 32'd0);
        check("hold_x", 32'(vga.oDATA_X), 32'd7);
        check("hold_y", 32'(vga.oDATA_Y), 32'd0);
      end
      if (n == 116) check("last_vis_blank", 32'(vga.oDISP_BLANK), 32'd0);
      if (n == 117) check("after_vis_blank", 32'(vga.oDISP_BLANK), 32'd1);
      if (n == 119) begin
        check("vfront_y", 32'(vga.oDATA_Y), 32'd2);
        check("vfront_x", 32'(vga.oDATA_X), 32'd7);
        check("vfront_blank", 32'(vga.oDISP_BLANK), 32'd1);
      end
      if (n == 136) begin
        check("frame2_start", 32'(vga.oFRAME_START), 32'd1);
`ifdef VGATIMING_FRAME_CNT_EN
        check("frame2_fcnt", 32'(vga.oFRAME_CNT), 32'd2);
`endif
      end
    end
    check("hsync_line_cnt", 32'(hs_line), 32'd3);
    check("hsync_frame_cnt", 32'(hs_frame), 32'd24);
    check("vsync_frame_cnt", 32'(vs_frame), 32'd34);
    check("visible_cnt", 32'(blank_cnt), 32'd24);
    check("first_visible", 32'(first_blank), 32'd75);
    check("req_cnt", 32'(req_cnt), 32'd24);
    check("first_req", 32'(first_req), 32'd73);
    check("frame_start_cnt", 32'(fs_cnt), 32'd2);
    check("line_start_cnt", 32'(ls_cnt), 32'd16);

    // Advance to state (h=9,v=5); the counter then sits at h=10 when enable drops
    repeat (95) step();
    check("pre_drop_blank", 32'(vga.oDISP_BLANK), 32'd0);
    check("pre_drop_req", 32'(vga.oDATA_REQ), 32'd1);
    check("pre_drop_x", 32'(vga.oDATA_X), 32'd4);
    check("pre_drop_y", 32'(vga.oDATA_Y), 32'd1);
    vga.iENABLE = 1'b0;
    step();
    check_idle("drop");
    for (int k = 0; k < 4; k++) begin
      step();
      check("drop_hold_blank", 32'(vga.oDISP_BLANK), 32'd1);
      check("drop_hold_frame", 32'(vga.oFRAME_START), 32'd0);
    end
`ifdef VGATIMING_FRAME_CNT_EN
    check("drop_fcnt_hold", 32'(vga.oFRAME_CNT), 32'd3);
`endif
    vga.iENABLE = 1'b1;
    step();
    check("reen_frame_start", 32'(vga.oFRAME_START), 32'd1);
    check("reen_line_start", 32'(vga.oLINE_START), 32'd1);
    check("reen_hsync", 32'(vga.oDISP_HSYNC), 32'd0);
    check("reen_vsync", 32'(vga.oDISP_VSYNC), 32'd1);
`ifdef VGATIMING_FRAME_CNT_EN
    check("reen_fcnt", 32'(vga.oFRAME_CNT), 32'd4);
`endif
    step();
    check("reen_h1_frame", 32'(vga.oFRAME_START), 32'd0);
    check("reen_h1_hsync", 32'(vga.oDISP_HSYNC), 32'd0);

    // Reset asserted between clock edges must idle the outputs immediately
    #3 rst_n = 1'b0;
    #1;
    check_idle("async_rst");
`ifdef VGATIMING_FRAME_CNT_EN
    check("async_rst_fcnt", 32'(vga.oFRAME_CNT), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_frame_start", 32'(vga.oFRAME_START), 32'd1);
    check("post_rst_hsync", 32'(vga.oDISP_HSYNC), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
